rx_sample_pacer: RTL and testbench

Paces four-channel hydrophone sample frames into the phase-difference datapath. Buffers frames arriving on a valid/ready input in a small FIFO and releases one frame every CADENCE+1 clocks on rx1..rx4, qualified by a one-cycle enable strobe. It is the producer side of the all_phase sample interface and replaces bench-side file stimulus with synthesizable pacing logic fed from the ADC front end.

---
 rtl/rx_sample_pacer_if.sv | 34 +++
 rtl/rx_sample_pacer.sv | 131 +++++++++++++
 tb/tb_rx_sample_pacer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_sample_pacer_if.sv
// Sample-frame bus between the ADC front end, the pacer and the phase datapath.
// Latency: none (wires only).
// Backpressure: in_ready qualifies in_valid; the rx side has no backpressure (enable strobe only).
//
// Signals:
//   in_valid / in_ready      : frame handshake into the pacer
//   in_ch0..in_ch3           : 16-bit signed input frame
//   rx1..rx4                 : 16-bit signed paced frame (rx1 = ch0 ... rx4 = ch3)
//   enable                   : one-cycle strobe marking a new rx frame
interface rx_sample_pacer_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_ch0;
    logic signed [15:0] in_ch1;
    logic signed [15:0] in_ch2;
    logic signed [15:0] in_ch3;
    logic signed [15:0] rx1;
    logic signed [15:0] rx2;
    logic signed [15:0] rx3;
    logic signed [15:0] rx4;
    logic               enable;

    // Producer of input frames / consumer of paced frames.
    modport master (
        output in_valid, in_ch0, in_ch1, in_ch2, in_ch3,
        input  in_ready, rx1, rx2, rx3, rx4, enable
    );

    // The pacer itself.
    modport slave (
        input  in_valid, in_ch0, in_ch1, in_ch2, in_ch3,
        output in_ready, rx1, rx2, rx3, rx4, enable
    );
endinterface

// File: rtl/rx_sample_pacer.sv
// Paces buffered four-channel hydrophone frames onto rx1..rx4 once every CADENCE+1 clocks.
// Latency: at least 1 edge from push to output, otherwise until the next pacing tick.
// Backpressure: in_ready drops while the FIFO is full; a tick with an empty FIFO sets sticky underrun.
//
// Ports:
//   clock, reset (sync, active-high), run (level, 1 = pacing active)
//   bus         : input handshake + frame, paced rx1..rx4 and enable strobe
//   underrun    : sticky, a tick found the FIFO empty (cleared by reset only)
//   frames_sent : frames released, wraps at 1024
//   fifo_level  : frames currently buffered
module rx_sample_pacer #(
    parameter int CADENCE    = 511,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    rx_sample_pacer_if.slave              bus,
    output logic                          underrun,
    output logic [9:0]                    frames_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic signed [15:0] ch3;
        logic signed [15:0] ch2;
        logic signed [15:0] ch1;
        logic signed [15:0] ch0;
    } frame_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [9:0]      cnt;
    frame_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            full;
    logic            empty;
    logic            push;
    logic            tick;
    logic            pop;
    frame_t          head;

    assign full   = (level == LW'(FIFO_DEPTH));
    assign empty  = (level == '0);
    assign bus.in_ready = !full && !reset;
    assign push   = bus.in_valid && bus.in_ready;
    // Dropping run wins over a tick on the same edge, hence run in the term.
    assign tick   = (state == RUN) && run && (cnt == '0);
    // The pop reads the registered head; a same-edge push lands in another slot.
    assign pop    = tick && !empty;
    assign head   = mem[rd_ptr];
    assign fifo_level = level;

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 10'(CADENCE);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            bus.rx1     <= '0;
            bus.rx2     <= '0;
            bus.rx3     <= '0;
            bus.rx4     <= '0;
            bus.enable  <= 1'b0;
            underrun    <= 1'b0;
            frames_sent <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            case (state)
                IDLE: begin
                    bus.enable <= 1'b0;
                    cnt        <= 10'(CADENCE);
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state      <= IDLE;
                        cnt        <= 10'(CADENCE);
                        bus.enable <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt        <= cnt - 10'd1;
                        bus.enable <= 1'b0;
                    end else begin
                        cnt <= 10'(CADENCE);
                        if (!empty) begin
                            bus.rx1     <= head.ch0;
                            bus.rx2     <= head.ch1;
                            bus.rx3     <= head.ch2;
                            bus.rx4     <= head.ch3;
                            bus.enable  <= 1'b1;
                            frames_sent <= frames_sent + 10'd1;
                        end else begin
                            bus.enable <= 1'b0;
                            underrun   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_sample_pacer.sv
// Self-checking bench for rx_sample_pacer (CADENCE=3, FIFO_DEPTH=8).
// Latency: n/a.
// Backpressure: drives in_valid against in_ready.
module tb_rx_sample_pacer;
    localparam int C = 3;
    localparam int D = 8;
    localparam int P = C + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       underrun;
    logic [9:0] frames_sent;
    logic [3:0] fifo_level;

    rx_sample_pacer_if bus();

    rx_sample_pacer #(.CADENCE(C), .FIFO_DEPTH(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .bus         (bus),
        .underrun    (underrun),
        .frames_sent (frames_sent),
        .fifo_level  (fifo_level)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        shortint c0;
        shortint c1;
        shortint c2;
        shortint c3;
    } frm_t;

    // Reference model: a frame queue plus the edge index at which pacing started.
    // Ticks fall on edges that are a whole number of periods after the start edge.
    frm_t mq[$];
    bit   m_running = 0;
    int   m_start   = 0;
    int   edge_n    = 0;
    frm_t m_rx      = '{0, 0, 0, 0};
    bit   m_en      = 0;
    bit   m_und     = 0;
    int   m_sent    = 0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit next_is_tick();
        return m_running && (edge_n > m_start) && ((edge_n - m_start) % P == 0);
    endfunction

    function automatic void model_edge(bit r, bit rn, bit v, frm_t f);
        bit acc;
        acc = !r && v && (mq.size() < D);
        if (r) begin
            mq.delete();
            m_rx = '{0, 0, 0, 0};
            m_en = 0;
            m_und = 0;
            m_sent = 0;
            m_running = 0;
        end else begin
            m_en = 0;
            if (m_running) begin
                if (!rn) begin
                    m_running = 0;
                end else if ((edge_n - m_start) % P == 0) begin
                    if (mq.size() > 0) begin
                        m_rx = mq.pop_front();
                        m_en = 1;
                        m_sent = (m_sent + 1) % 1024;
                    end else begin
                        m_und = 1;
                    end
                end
            end else if (rn) begin
                m_running = 1;
                m_start = edge_n;
            end
            if (acc) mq.push_back(f);
        end
        edge_n++;
    endfunction

    // One clock: drive, check in_ready, clock edge, update model, check outputs.
    task automatic step(input bit r, input bit rn, input bit v, input frm_t f);
        reset = r;
        run = rn;
        bus.in_valid = v;
        bus.in_ch0 = f.c0;
        bus.in_ch1 = f.c1;
        bus.in_ch2 = f.c2;
        bus.in_ch3 = f.c3;
        #1;
        chk("in_ready", int'(bus.in_ready), int'(!r && (mq.size() < D)));
        @(posedge clock);
        model_edge(r, rn, v, f);
        #1;
        chk("enable", int'(bus.enable), int'(m_en));
        chk("rx1", bus.rx1, m_rx.c0);
        chk("rx2", bus.rx2, m_rx.c1);
        chk("rx3", bus.rx3, m_rx.c2);
        chk("rx4", bus.rx4, m_rx.c3);
        chk("underrun", int'(underrun), int'(m_und));
        chk("frames_sent", int'(frames_sent), m_sent);
        chk("fifo_level", int'(fifo_level), mq.size());
    endtask

    typedef struct {
        bit      r;
        bit      rn;
        bit      v;
        shortint d0, d1, d2, d3;
        bit      en;
        shortint x1, x4;
        int      lvl;
        bit      und;
        int      sent;
    } vec_t;

    vec_t tbl[20];
    frm_t z;
    frm_t f;

    initial begin
        int n;
        int k;
        bit rn_r;
        z = '{0, 0, 0, 0};

        // Hand-derived directed vectors, expected values after each edge.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 100, -100, 200, -200, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 2, 3, 4,          0, 0, 0, 2, 0, 0};
        for (int i = 3; i <= 6; i++)
            tbl[i] = '{0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 2, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0,          1, 100, -200, 1, 0, 1};
        for (int i = 8; i <= 10; i++)
            tbl[i] = '{0, 1, 0, 0, 0, 0, 0,       0, 100, -200, 1, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 0,          1, 1, 4, 0, 0, 2};
        for (int i = 12; i <= 14; i++)
            tbl[i] = '{0, 1, 0, 0, 0, 0, 0,       0, 1, 4, 0, 0, 2};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 0,          0, 1, 4, 0, 1, 2};
        tbl[16] = '{0, 1, 1, 7, 8, 9, 10,         0, 1, 4, 1, 1, 2};
        tbl[17] = '{0, 1, 0, 0, 0, 0, 0,          0, 1, 4, 1, 1, 2};
        tbl[18] = '{0, 1, 0, 0, 0, 0, 0,          0, 1, 4, 1, 1, 2};
        tbl[19] = '{0, 1, 0, 0, 0, 0, 0,          1, 7, 10, 0, 1, 3};

        reset = 1'b1;
        run = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ch0 = '0;
        bus.in_ch1 = '0;
        bus.in_ch2 = '0;
        bus.in_ch3 = '0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 20; i++) begin
            f = '{tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3};
            step(tbl[i].r, tbl[i].rn, tbl[i].v, f);
            chk($sformatf("vec%0d_en", i), int'(bus.enable), int'(tbl[i].en));
            chk($sformatf("vec%0d_rx1", i), bus.rx1, tbl[i].x1);
            chk($sformatf("vec%0d_rx4", i), bus.rx4, tbl[i].x4);
            chk($sformatf("vec%0d_lvl", i), int'(fifo_level), tbl[i].lvl);
            chk($sformatf("vec%0d_und", i), int'(underrun), int'(tbl[i].und));
            chk($sformatf("vec%0d_sent", i), int'(frames_sent), tbl[i].sent);
        end

        // Fill to full while idle, 9th frame refused, then drain in order.
        step(1, 0, 0, z);
        for (int i = 1; i <= 9; i++) begin
            f = '{shortint'(i * 10), shortint'(-i), shortint'(i * 1000), shortint'(-i * 1000)};
            step(0, 0, 1, f);
        end
        chk("full_level", int'(fifo_level), 8);
        chk("full_ready", int'(bus.in_ready), 0);
        n = 0;
        for (int s = 0; s < 40; s++) begin
            step(0, 1, 0, z);
            if (bus.enable) begin
                n++;
                chk("drain_rx1", bus.rx1, n * 10);
                chk("drain_rx4", bus.rx4, -n * 1000);
            end
        end
        chk("drain_count", n, 8);

        // Push on a tick edge with an empty FIFO: underrun, frame goes out next tick.
        for (int s = 0; s < 10 && !next_is_tick(); s++) step(0, 1, 0, z);
        f = '{11, 22, 33, 44};
        step(0, 1, 1, f);
        chk("tickpush_en", int'(bus.enable), 0);
        chk("tickpush_und", int'(underrun), 1);
        chk("tickpush_lvl", int'(fifo_level), 1);
        n = 0;
        k = 0;
        while (k < 10 && !bus.enable) begin
            step(0, 1, 0, z);
            k++;
        end
        chk("tickpush_wait", k, P);
        chk("tickpush_rx1", bus.rx1, 11);
        chk("tickpush_rx4", bus.rx4, 44);
        chk("tickpush_und_stays", int'(underrun), 1);

        // Fill to level 3 between ticks, then push and pop on the same edge.
        for (int i = 0; i < 3; i++) begin
            f = '{shortint'(50 + i), 0, 0, 0};
            step(0, 1, 1, f);
        end
        chk("pp_pre_lvl", int'(fifo_level), 3);
        chk("pp_is_tick", int'(next_is_tick()), 1);
        f = '{60, 0, 0, 0};
        step(0, 1, 1, f);
        chk("pp_lvl", int'(fifo_level), 3);
        chk("pp_en", int'(bus.enable), 1);
        chk("pp_rx1", bus.rx1, 50);

        // Drop run on a tick edge, then restart from a full period.
        for (int s = 0; s < 10 && !next_is_tick(); s++) step(0, 1, 0, z);
        step(0, 0, 0, z);
        chk("drop_en", int'(bus.enable), 0);
        chk("drop_lvl", int'(fifo_level), 3);
        for (int s = 0; s < 3; s++) step(0, 0, 0, z);
        chk("idle_en", int'(bus.enable), 0);
        step(0, 1, 0, z);
        k = 0;
        while (k < 20 && !bus.enable) begin
            step(0, 1, 0, z);
            k++;
        end
        chk("restart_wait", k, P);
        chk("restart_rx1", bus.rx1, 51);

        // Reset mid-run with five frames buffered.
        step(0, 0, 0, z);
        while (mq.size() < 5) step(0, 0, 1, '{1, 1, 1, 1});
        step(0, 1, 0, z);
        step(0, 1, 0, z);
        chk("prereset_lvl", int'(fifo_level), 5);
        step(1, 1, 0, z);
        chk("rst_lvl", int'(fifo_level), 0);
        chk("rst_rx1", bus.rx1, 0);
        chk("rst_rx4", bus.rx4, 0);
        chk("rst_en", int'(bus.enable), 0);
        chk("rst_und", int'(underrun), 0);
        chk("rst_sent", int'(frames_sent), 0);

        // 1025 extreme-value frames: counter wraps to 1, data bit-exact.
        n = 0;
        k = 0;
        for (int s = 0; s < 1025 * P + 50 && n < 1025; s++) begin
            f = '{(k % 2) ? 16'sh7FFF : 16'sh8000, (k % 2) ? 16'sh8000 : 16'sh7FFF, 16'sh7FFF, 16'sh8000};
            if (mq.size() < D) begin
                step(0, 1, 1, f);
                k++;
            end else begin
                step(0, 1, 0, z);
            end
            if (bus.enable) begin
                chk("wrap_rx1", bus.rx1, (n % 2) ? 32767 : -32768);
                chk("wrap_rx2", bus.rx2, (n % 2) ? -32768 : 32767);
                n++;
            end
        end
        chk("wrap_count", n, 1025);
        chk("wrap_sent", int'(frames_sent), 1);

        // Randomized traffic against the model.
        rn_r = 1'b1;
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(0, 19) == 0) rn_r = !rn_r;
            f = '{shortint'($urandom), shortint'($urandom), shortint'($urandom), shortint'($urandom)};
            step(($urandom_range(0, 299) == 0), rn_r, ($urandom_range(0, 2) == 0), f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
